// File: rtl/riscv_pkg.sv
// Shared ALU definitions: one-hot op indices, FSM states and iteration-unit op codes.
package riscv_pkg;

    // One-hot bit positions within cmd_i
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_XOR  = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;
    localparam int unsigned ALU_MUL  = 10;

    // Width stays fixed whether or not the multiplier is built
    localparam int unsigned NB_ALU_OP = 11;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} alu_seq_state_t;

    typedef enum logic [1:0] {ITER_SLL, ITER_SRL, ITER_SRA, ITER_MUL} iter_op_t;

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for alu_seq: one shift bit, or one shift-add multiplier step, per enable.
// The multiplier registers exist only when ALU_MUL_EN is defined.
module alu_iter_unit
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start_i,
    input  iter_op_t        op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [SHW-1:0]  shamt_i,
    input  logic            en_i,
    output logic [XLEN-1:0] result_o,
    output logic            last_o
);

    iter_op_t        op_q;
    logic [SHW:0]    cnt_q;
    logic [XLEN-1:0] work_q;
    logic [XLEN-1:0] work_step;

`ifdef ALU_MUL_EN
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
`else
    logic unused_b;
    assign unused_b = ^b_i;
`endif

    // Value of the working register after one more step; also the final result on the last step
    always_comb begin
        work_step = work_q;
        case (op_q)
            ITER_SLL: work_step = {work_q[XLEN-2:0], 1'b0};
            ITER_SRL: work_step = {1'b0, work_q[XLEN-1:1]};
            ITER_SRA: work_step = {work_q[XLEN-1], work_q[XLEN-1:1]};
`ifdef ALU_MUL_EN
            ITER_MUL: work_step = mplier_q[0] ? (work_q + mcand_q) : work_q;
`endif
            default:  work_step = work_q;
        endcase
    end

    assign result_o = work_step;
    assign last_o   = (cnt_q == (SHW+1)'(1));

    // Load operands on start, then step and count down on each enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= ITER_SLL;
            cnt_q    <= '0;
            work_q   <= '0;
`ifdef ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else if (start_i) begin
            op_q <= op_i;
`ifdef ALU_MUL_EN
            if (op_i == ITER_MUL) begin
                cnt_q    <= (SHW+1)'(XLEN);
                work_q   <= '0;
                mcand_q  <= a_i;
                mplier_q <= b_i;
            end else begin
                cnt_q  <= {1'b0, shamt_i};
                work_q <= a_i;
            end
`else
            cnt_q  <= {1'b0, shamt_i};
            work_q <= a_i;
`endif
        end else if (en_i) begin
            cnt_q  <= cnt_q - (SHW+1)'(1);
            work_q <= work_step;
`ifdef ALU_MUL_EN
            mcand_q  <= {mcand_q[XLEN-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
`endif
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-cycle arithmetic/logic, iterative shifts and,
// when ALU_MUL_EN is defined, an iterative shift-add multiplier. Result is registered.
module alu_seq
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [NB_ALU_OP-1:0] cmd_i,
    input  logic [XLEN-1:0]      rs1_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    input  logic                 flush_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [XLEN-1:0]      data_o,
    output logic                 busy_o
);

    alu_seq_state_t  state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [XLEN-1:0] sc_res;
    logic [XLEN-1:0] iter_res;
    logic [SHW-1:0]  shamt;
    logic            one_hot, legal, is_shift, is_mul, accept;
    logic            iter_start, iter_en, iter_last;
    iter_op_t        iter_op;

    assign one_hot = $onehot(cmd_i);
    assign shamt   = rs2_data_i[SHW-1:0];

`ifdef ALU_MUL_EN
    assign legal  = one_hot;
    assign is_mul = one_hot & cmd_i[ALU_MUL];
`else
    // MUL encoding is kept but decodes as illegal
    assign legal  = one_hot & ~cmd_i[ALU_MUL];
    assign is_mul = 1'b0;
`endif

    assign is_shift = legal & (cmd_i[ALU_SLL] | cmd_i[ALU_SRL] | cmd_i[ALU_SRA]);

    assign ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == DONE) & ready_i));
    assign accept  = valid_i & ready_o;
    assign valid_o = (state_q == DONE);
    assign busy_o  = (state_q == SHIFT) | (state_q == MUL);
    assign data_o  = data_q;

    // Single-cycle result; a zero-amount shift passes operand A straight through
    always_comb begin
        sc_res = '0;
        if (legal) begin
            unique case (1'b1)
                cmd_i[ALU_ADD]:  sc_res = rs1_data_i + rs2_data_i;
                cmd_i[ALU_SUB]:  sc_res = rs1_data_i - rs2_data_i;
                cmd_i[ALU_SLT]:  sc_res = {{(XLEN-1){1'b0}},
                                           $signed(rs1_data_i) < $signed(rs2_data_i)};
                cmd_i[ALU_SLTU]: sc_res = {{(XLEN-1){1'b0}}, rs1_data_i < rs2_data_i};
                cmd_i[ALU_AND]:  sc_res = rs1_data_i & rs2_data_i;
                cmd_i[ALU_OR]:   sc_res = rs1_data_i | rs2_data_i;
                cmd_i[ALU_XOR]:  sc_res = rs1_data_i ^ rs2_data_i;
                cmd_i[ALU_SLL], cmd_i[ALU_SRL], cmd_i[ALU_SRA]: sc_res = rs1_data_i;
                default:         sc_res = '0;
            endcase
        end
    end

    // Map the decoded op onto the iteration unit's step kind
    always_comb begin
        iter_op = ITER_SLL;
        if (is_mul) begin
            iter_op = ITER_MUL;
        end else if (cmd_i[ALU_SRL]) begin
            iter_op = ITER_SRL;
        end else if (cmd_i[ALU_SRA]) begin
            iter_op = ITER_SRA;
        end
    end

    alu_iter_unit #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (iter_start),
        .op_i     (iter_op),
        .a_i      (rs1_data_i),
        .b_i      (rs2_data_i),
        .shamt_i  (shamt),
        .en_i     (iter_en),
        .result_o (iter_res),
        .last_o   (iter_last)
    );

    // Next state and result: iterate, drain, dispatch accepted requests, flush wins over all
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        iter_start = 1'b0;
        iter_en    = 1'b0;
        case (state_q)
            SHIFT, MUL: begin
                iter_en = 1'b1;
                if (iter_last) begin
                    state_d = DONE;
                    data_d  = iter_res;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase
        // accept implies IDLE or a draining DONE, so this never collides with iteration
        if (accept) begin
            if (is_shift && (shamt != '0)) begin
                state_d    = SHIFT;
                iter_start = 1'b1;
            end else if (is_mul) begin
                state_d    = MUL;
                iter_start = 1'b1;
            end else begin
                state_d = DONE;
                data_d  = sc_res;
            end
        end
        if (flush_i) begin
            state_d = IDLE;
            data_d  = data_q;
            iter_en = 1'b0;
        end
    end

    // State and output result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (XLEN=32): a cycle-level reference model checked every
// cycle, plus directed vectors with literal expectations. Honours ALU_MUL_EN like the DUT.
module tb_alu_seq;
    import riscv_pkg::*;

    localparam logic [10:0] C_ADD  = 11'(1) << ALU_ADD;
    localparam logic [10:0] C_SUB  = 11'(1) << ALU_SUB;
    localparam logic [10:0] C_SLT  = 11'(1) << ALU_SLT;
    localparam logic [10:0] C_SLTU = 11'(1) << ALU_SLTU;
    localparam logic [10:0] C_AND  = 11'(1) << ALU_AND;
    localparam logic [10:0] C_OR   = 11'(1) << ALU_OR;
    localparam logic [10:0] C_XOR  = 11'(1) << ALU_XOR;
    localparam logic [10:0] C_SLL  = 11'(1) << ALU_SLL;
    localparam logic [10:0] C_SRL  = 11'(1) << ALU_SRL;
    localparam logic [10:0] C_SRA  = 11'(1) << ALU_SRA;
    localparam logic [10:0] C_MUL  = 11'(1) << ALU_MUL;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [10:0] cmd_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] data_o;
    logic        busy_o;

    int n_asserts = 0;
    int n_fail = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .cmd_i      (cmd_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .data_o     (data_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU written from the operation rules
    function automatic logic [31:0] ref_alu(input logic [10:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        if ($countones(c) != 1) return 32'h0;
        if (c == C_ADD)  return a + b;
        if (c == C_SUB)  return a - b;
        if (c == C_SLT)  return ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
        if (c == C_SLTU) return (a < b) ? 32'h1 : 32'h0;
        if (c == C_AND)  return a & b;
        if (c == C_OR)   return a | b;
        if (c == C_XOR)  return a ^ b;
        if (c == C_SLL)  return a << b[4:0];
        if (c == C_SRL)  return a >> b[4:0];
        if (c == C_SRA)  return 32'($signed(a) >>> b[4:0]);
`ifdef ALU_MUL_EN
        if (c == C_MUL)  return a * b;
`endif
        return 32'h0;
    endfunction

    // Cycles from acceptance edge to valid_o
    function automatic int ref_lat(input logic [10:0] c, input logic [31:0] b);
        if ($countones(c) != 1) return 1;
        if ((c == C_SLL) || (c == C_SRL) || (c == C_SRA)) return 1 + int'(b[4:0]);
`ifdef ALU_MUL_EN
        if (c == C_MUL) return 33;
`endif
        return 1;
    endfunction

    // Model state: result held, remaining busy cycles, pending result
    logic        m_hold = 1'b0;
    int          m_busy = 0;
    logic [31:0] m_data = '0;
    logic [31:0] m_pend = '0;
    logic        m_ready;
    logic [31:0] m_res;
    int          m_lat;

    always_comb begin
        m_ready = !flush_i && ((!m_hold && (m_busy == 0)) || (m_hold && ready_i));
        m_res   = ref_alu(cmd_i, rs1_data_i, rs2_data_i);
        m_lat   = ref_lat(cmd_i, rs2_data_i);
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hold <= 1'b0;
            m_busy <= 0;
            m_data <= '0;
        end else if (flush_i) begin
            m_hold <= 1'b0;
            m_busy <= 0;
        end else begin
            if (m_busy == 1) begin
                m_busy <= 0;
                m_hold <= 1'b1;
                m_data <= m_pend;
            end else if (m_busy > 1) begin
                m_busy <= m_busy - 1;
            end else if (m_hold && ready_i) begin
                m_hold <= 1'b0;
            end
            if (valid_i && m_ready) begin
                if (m_lat == 1) begin
                    m_hold <= 1'b1;
                    m_data <= m_res;
                end else begin
                    m_hold <= 1'b0;
                    m_busy <= m_lat - 1;
                    m_pend <= m_res;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (reset_n) begin
            check("valid_o", {31'b0, valid_o}, {31'b0, m_hold});
            check("busy_o", {31'b0, busy_o}, {31'b0, m_busy > 0});
            check("ready_o", {31'b0, ready_o}, {31'b0, m_ready});
            check("data_o", data_o, m_data);
        end
    end

    // Issue one op (called at posedge+1), measure latency and busy cycles
    task automatic do_op(input string nm, input logic [10:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_d, input int exp_lat,
                         input int exp_busy);
        int w, lat, bz;
        w = 0;
        while (!ready_o && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        valid_i = 1'b1; cmd_i = c; rs1_data_i = a; rs2_data_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 1; bz = 0;
        while (!valid_o && lat < 80) begin
            if (busy_o) bz++;
            @(posedge clk); #1;
            lat++;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " data"}, data_o, exp_d);
        if (exp_busy >= 0) check({nm, " busy cycles"}, bz, exp_busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rose;
        // Reset values
        #12;
        check("reset valid_o", {31'b0, valid_o}, 32'h0);
        check("reset busy_o", {31'b0, busy_o}, 32'h0);
        check("reset data_o", data_o, 32'h0);
        check("reset ready_o", {31'b0, ready_o}, 32'h1);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        do_op("ADD ovf", C_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1, 0);
        do_op("SLT", C_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1, 0);
        do_op("SLTU", C_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0);
        do_op("SRA4", C_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000, 5, 4);
        do_op("SLL0", C_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678, 1, 0);
        do_op("SRL3", C_SRL, 32'hF000_0000, 32'h3, 32'h1E00_0000, 4, 3);

        // Back-to-back single-cycle ops
        valid_i = 1'b1; cmd_i = C_XOR; rs1_data_i = 32'hF0F0_F0F0; rs2_data_i = 32'h0FF0_0FF0;
        @(posedge clk); #1;
        check("b2b XOR", data_o, 32'hFF00_FF00);
        cmd_i = C_AND;
        @(posedge clk); #1;
        check("b2b AND", data_o, 32'h00F0_00F0);
        cmd_i = C_SUB; rs1_data_i = 32'd5; rs2_data_i = 32'd7;
        @(posedge clk); #1;
        check("b2b SUB", data_o, 32'hFFFF_FFFE);
        check("b2b SUB valid", {31'b0, valid_o}, 32'h1);
        valid_i = 1'b0; ready_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("stall data", data_o, 32'hFFFF_FFFE);
        check("stall ready_o", {31'b0, ready_o}, 32'h0);
        ready_i = 1'b1;
        @(posedge clk); #1;

        // Flush in the middle of a long shift
        valid_i = 1'b1; cmd_i = C_SRL; rs1_data_i = 32'h8000_0000; rs2_data_i = 32'd31;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("pre-flush busy", {31'b0, busy_o}, 32'h1);
        flush_i = 1'b1; valid_i = 1'b1; cmd_i = C_ADD; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
        #1 check("flush ready_o", {31'b0, ready_o}, 32'h0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        check("post-flush busy", {31'b0, busy_o}, 32'h0);
        check("post-flush valid", {31'b0, valid_o}, 32'h0);
        rose = 1'b0;
        repeat (35) begin
            @(posedge clk); #1;
            if (valid_o) rose = 1'b1;
        end
        check("flush valid never rose", {31'b0, rose}, 32'h0);
        do_op("ADD after flush", C_ADD, 32'd2, 32'd3, 32'd5, 1, 0);

        // Asynchronous reset in the middle of a shift
        valid_i = 1'b1; cmd_i = C_SLL; rs1_data_i = 32'h1; rs2_data_i = 32'd20;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check("pre-reset busy", {31'b0, busy_o}, 32'h1);
        check("pre-reset data", data_o, 32'd5);
        #1 reset_n = 1'b0;
        #1;
        check("async reset busy", {31'b0, busy_o}, 32'h0);
        check("async reset valid", {31'b0, valid_o}, 32'h0);
        check("async reset data", data_o, 32'h0);
        check("async reset ready", {31'b0, ready_o}, 32'h1);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        do_op("illegal ADD|OR", C_ADD | C_OR, 32'h1234, 32'h5678, 32'h0, 1, 0);
        do_op("illegal zero", 11'h0, 32'h1234, 32'h5678, 32'h0, 1, 0);
`ifdef ALU_MUL_EN
        do_op("MUL", C_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33, 32);
        do_op("MUL small", C_MUL, 32'd1234, 32'd5678, 32'd7006652, 33, 32);
`else
        do_op("MUL disabled", C_MUL, 32'hFFFF_FFFF, 32'd3, 32'h0, 1, 0);
`endif
        do_op("OR", C_OR, 32'hA000_0001, 32'h0500_0010, 32'hA500_0011, 1, 0);

        repeat (3) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
